// File: rtl/cim_ahb_dma_master.sv
// cim_ahb_dma_master: AHB-Lite master DMA moving word blocks between system memory and the local CIM buffer.
//   cmd_*   : command handshake (valid/ready, direction, word-aligned byte address, word count)
//   h*      : AHB-Lite master port, pipelined single-word NONSEQ transfers
//   buf_*   : local buffer read port (1-cycle latency) and write port
//   busy/done/error : status, done/error are 1-cycle pulses
module cim_ahb_dma_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BUF_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp,
    output logic                  buf_re,
    output logic [BUF_AW-1:0]     buf_raddr,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    output logic                  buf_we,
    output logic [BUF_AW-1:0]     buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    // ADDR: address phases still to issue; LAST: only the final data phase left;
    // ERR: between the two cycles of an ERROR response, address pipeline cancelled.
    typedef enum logic [1:0] {IDLE, ADDR, LAST, ERR} state_t;
    state_t                state_q, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
    logic [LEN_WIDTH-1:0]  rem_q, rem_nx;
    logic [BUF_AW-1:0]     aidx_q, aidx_nx, didx_q, didx_nx;
    logic                  wr_q, wr_nx, dph_q, dph_nx, done_q, done_nx, err_q, err_nx;
    logic                  bus_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            aidx_q  <= '0;
            didx_q  <= '0;
            wr_q    <= 1'b0;
            dph_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            addr_q  <= addr_nx;
            rem_q   <= rem_nx;
            aidx_q  <= aidx_nx;
            didx_q  <= didx_nx;
            wr_q    <= wr_nx;
            dph_q   <= dph_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
        end
    end

    // an ERROR response can only belong to a beat in its data phase
    assign bus_err = dph_q && hresp;

    always_comb begin
        state_nx = state_q;
        addr_nx  = addr_q;
        rem_nx   = rem_q;
        aidx_nx  = aidx_q;
        didx_nx  = didx_q;
        wr_nx    = wr_q;
        dph_nx   = dph_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd_addr[1:0] != 2'b00) begin
                    err_nx = 1'b1;
                end else if (cmd_len == '0) begin
                    done_nx = 1'b1;
                end else begin
                    state_nx = ADDR;
                    addr_nx  = cmd_addr;
                    rem_nx   = cmd_len;
                    wr_nx    = cmd_write;
                    aidx_nx  = '0;
                end
            end
            ADDR, LAST: if (bus_err) begin
                // first error cycle parks in ERR; a lone second cycle ends at once
                state_nx = hready ? IDLE : ERR;
                err_nx   = hready;
                dph_nx   = !hready;
            end else if (hready) begin
                dph_nx = (state_q == ADDR);
                if (state_q == ADDR) begin
                    addr_nx  = addr_q + ADDR_WIDTH'(4);
                    aidx_nx  = aidx_q + BUF_AW'(1);
                    didx_nx  = aidx_q;
                    rem_nx   = rem_q - LEN_WIDTH'(1);
                    state_nx = (rem_q == LEN_WIDTH'(1)) ? LAST : ADDR;
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            ERR: if (hready) begin
                state_nx = IDLE;
                err_nx   = 1'b1;
                dph_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign error     = err_q;
    assign haddr     = addr_q;
    assign htrans    = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign hwrite    = wr_q;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    // buffer word fetched at address acceptance arrives for the data phase and is held through waits
    assign hwdata    = (dph_q && wr_q) ? buf_rdata : '0;
    assign buf_re    = (state_q == ADDR) && hready && wr_q && !bus_err;
    assign buf_raddr = aidx_q;
    assign buf_we    = dph_q && !wr_q && hready && !hresp;
    assign buf_waddr = didx_q;
    assign buf_wdata = hrdata;
endmodule

// File: tb/tb_cim_ahb_dma_master.sv
// tb_cim_ahb_dma_master: randomized scoreboard bench for cim_ahb_dma_master with a behavioural AHB slave and buffer.
module tb_cim_ahb_dma_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_ready;
    logic [31:0] haddr, hwdata, hrdata, buf_rdata, buf_wdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp, buf_re, buf_we, busy, done, error;
    logic [2:0]  hsize, hburst;
    logic [9:0]  buf_raddr, buf_waddr;

    cim_ahb_dma_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nmis = 0;
    int last_end = 0;
    logic [32:0] exp_addr[$];
    logic [31:0] exp_wd[$];
    logic [41:0] exp_bw[$];
    logic [1:0]  exp_end[$];
    logic [31:0] bufmem[1024];
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h1, stall_addr = 32'h1;
    int          stall_n = 0, wait_max = 0;

    function automatic logic [31:0] rdf(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic unexp(string n);
        nvec++;
        nmis++;
        $display("FAIL %s: got an event want none", n);
    endtask

    // AHB slave and buffer memory: decides hready/hresp/hrdata for the coming cycle
    initial begin
        logic        dp, derr, dst, rd;
        logic [31:0] da;
        logic [9:0]  ra;
        int          dwait;
        dp = 0; derr = 0; dst = 0; rd = 0; da = 0; ra = 0; dwait = 0;
        for (int i = 0; i < 1024; i++) bufmem[i] = $urandom;
        hready = 1'b1; hresp = 1'b0; hrdata = '0; buf_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dp = 0;
                rd = 0;
            end else begin
                if (dp && hready) dp = 0;
                if (htrans == 2'b10 && hready) begin
                    dp    = 1;
                    da    = haddr;
                    dwait = (haddr == stall_addr) ? stall_n : int'($urandom_range(wait_max, 0));
                    derr  = err_en && (haddr == err_addr);
                    dst   = 0;
                end
                rd = buf_re;
                ra = buf_raddr;
            end
            @(posedge clk);
            #1;
            if (!dp) begin
                hready = 1'b1; hresp = 1'b0;
            end else if (dwait > 0) begin
                hready = 1'b0; hresp = 1'b0; dwait--;
            end else if (derr) begin
                hresp = 1'b1; hready = dst; dst = 1;
            end else begin
                hready = 1'b1; hresp = 1'b0;
            end
            hrdata = rdf(da);
            if (rd) buf_rdata = bufmem[ra];
        end
    end

    // monitor: pops expected events as the DUT presents them
    initial begin
        logic        mdp, mdw, have_prev, p_hready, p_hresp, p_hwrite;
        logic [31:0] p_haddr, p_hwdata;
        logic [1:0]  p_htrans;
        logic [9:0]  p_raddr, p_waddr;
        logic [32:0] ea;
        logic [41:0] eb;
        mdp = 0; mdw = 0; have_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdp = 0;
                have_prev = 0;
                continue;
            end
            if (have_prev && !p_hready && !p_hresp) begin
                chk("hold_haddr", haddr, p_haddr);
                chk("hold_htrans", htrans, p_htrans);
                chk("hold_hwrite", hwrite, p_hwrite);
                chk("hold_hwdata", hwdata, p_hwdata);
                chk("hold_idx", {buf_raddr, buf_waddr}, {p_raddr, p_waddr});
            end
            if (htrans == 2'b10 && hready) begin
                if (exp_addr.size() == 0) unexp("addr_phase");
                else begin
                    ea = exp_addr.pop_front();
                    chk("haddr_hwrite", {hwrite, haddr}, ea);
                    chk("hsize_hburst", {hsize, hburst}, {3'b010, 3'b000});
                end
            end
            if (mdp && mdw && hready && !hresp) begin
                if (exp_wd.size() == 0) unexp("write_data");
                else chk("hwdata", hwdata, exp_wd.pop_front());
            end
            if (hready) begin
                mdp = (htrans == 2'b10);
                mdw = hwrite;
            end
            if (buf_we) begin
                if (exp_bw.size() == 0) unexp("buf_we");
                else begin
                    eb = exp_bw.pop_front();
                    chk("buf_write", {buf_waddr, buf_wdata}, eb);
                end
            end
            if (done || error) begin
                last_end = cyc;
                if (exp_end.size() == 0) unexp("done_error");
                else chk("done_error", {done, error}, exp_end.pop_front());
            end
            have_prev = 1; p_hready = hready; p_hresp = hresp; p_haddr = haddr;
            p_htrans = htrans; p_hwrite = hwrite; p_hwdata = hwdata;
            p_raddr = buf_raddr; p_waddr = buf_waddr;
        end
    end

    task automatic chk_reset();
        chk("rst_htrans_haddr", {htrans, haddr}, 34'h0);
        chk("rst_hwrite_hwdata", {hwrite, hwdata}, 33'h0);
        chk("rst_buf", {buf_re, buf_raddr, buf_we, buf_waddr}, 22'h0);
        chk("rst_status", {busy, done, error, cmd_ready}, 4'b0001);
    endtask

    // expected behaviour from the command alone: beats before the failing one complete,
    // the failing beat's address is the last one accepted
    task automatic issue(input logic w, input logic [31:0] a, input int len, input int eidx, output int t0);
        int k, nok, nad;
        k = 0;
        while (!cmd_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        err_en   = (eidx >= 0);
        err_addr = a + 32'(4 * eidx);
        if (a[1:0] != 2'b00) exp_end.push_back(2'b01);
        else if (len == 0) exp_end.push_back(2'b10);
        else begin
            nok = (eidx < 0) ? len : eidx;
            nad = (eidx < 0) ? len : eidx + 1;
            for (int i = 0; i < nad; i++) exp_addr.push_back({w, a + 32'(4 * i)});
            for (int i = 0; i < nok; i++)
                if (w) exp_wd.push_back(bufmem[i % 1024]);
                else exp_bw.push_back({10'(i % 1024), rdf(a + 32'(4 * i))});
            exp_end.push_back((eidx < 0) ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 16'(len);
        t0 = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int t0, input int lat);
        int k;
        k = 0;
        while (exp_end.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("end_timeout", exp_end.size(), 0);
        if (lat >= 0) chk("latency", last_end - t0, lat);
        chk("leftover_beats", exp_addr.size() + exp_wd.size() + exp_bw.size(), 0);
    endtask

    task automatic run_cmd(input logic w, input logic [31:0] a, input int len, input int eidx, input int lat);
        int t0;
        issue(w, a, len, eidx, t0);
        finish_cmd(t0, lat);
    endtask

    initial begin
        int t0, len, eidx;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset();
        run_cmd(1'b0, 32'h1000, 4, -1, 6);
        stall_addr = 32'h3004; stall_n = 2;
        run_cmd(1'b1, 32'h3000, 3, -1, 7);
        stall_addr = 32'h1; stall_n = 0;
        run_cmd(1'b0, 32'h4000, 8, 2, 6);
        run_cmd(1'b0, 32'h5000, 0, -1, 1);
        run_cmd(1'b1, 32'h1002, 4, -1, 1);
        run_cmd(1'b0, 32'hFFFF_FFF8, 4, -1, 6);
        issue(1'b1, 32'h2000, 6, -1, t0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        exp_addr.delete(); exp_wd.delete(); exp_bw.delete(); exp_end.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_cmd(1'b0, 32'h6000, 2, -1, 4);
        wait_max = 2;
        for (int n = 0; n < 60; n++) begin
            len  = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(12, 1));
            a    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(9, 0) == 0) a[1:0] = 2'(($urandom_range(2, 0)) + 1);
            eidx = (len > 0 && $urandom_range(4, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            run_cmd(1'($urandom_range(1, 0)), a, len, eidx, -1);
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
